// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-boundary registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_ONE   = 2'd1,
    SLOT_TWO   = 2'd2
  } slot_state_e;

  localparam int PERF_CNT_W = 32;

  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_CTRL_W = 4;

  localparam int IF_ID_DATA_W  = 96;
  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_DATA_W  = 192;
  localparam int ID_EX_CTRL_W  = 12;
  localparam int EX_MEM_DATA_W = 128;
  localparam int EX_MEM_CTRL_W = 8;
  localparam int MEM_WB_DATA_W = 64;
  localparam int MEM_WB_CTRL_W = 6;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    logic [PERF_CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + PERF_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One elastic slot: main register, skid register, occupancy state and a
// registered upstream ready so no combinational ready path crosses the slot.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  slot_state_e       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              ready_q, ready_d;
  logic              in_fire_s, out_fire_s;

  // Next-state and payload movement for the slot.
  always_comb begin
    in_fire_s   = in_valid & ready_q;
    out_fire_s  = (state_q != SLOT_EMPTY) & out_ready;
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Flush wins over any simultaneous accept; data is left as-is.
      state_d     = SLOT_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (in_fire_s) begin
            state_d     = SLOT_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else begin
            state_d = SLOT_EMPTY;
          end
        end
        SLOT_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire_s) begin
            state_d     = SLOT_TWO;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_fire_s) begin
            state_d = SLOT_EMPTY;
          end else begin
            state_d = SLOT_ONE;
          end
        end
        SLOT_TWO: begin
          if (out_fire_s) begin
            state_d     = SLOT_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end else begin
            state_d = SLOT_TWO;
          end
        end
        default: begin
          state_d = SLOT_EMPTY;
        end
      endcase
    end
    ready_d = (state_d != SLOT_TWO);
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SLOT_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      ready_q     <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != SLOT_EMPTY);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register built from STAGES chained skid slots.
// Optional stall/bubble performance counters are enabled by PIPE_REG_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int STAGES = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [CTRL_W-1:0] In_ctrl,
  input  logic [DATA_W-1:0] In_data,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [CTRL_W-1:0] Out_ctrl,
  output logic [DATA_W-1:0] Out_data,
  input  logic              Flush,
  output logic [31:0]       Stall_cnt,
  output logic [31:0]       Bubble_cnt
);

  if (STAGES < 1) begin : g_bad_stages
    $error("pipe_stage_reg: STAGES must be at least 1");
  end

  logic              valid_s [0:STAGES];
  logic              ready_s [0:STAGES];
  logic [CTRL_W-1:0] ctrl_s  [0:STAGES];
  logic [DATA_W-1:0] data_s  [0:STAGES];

  assign valid_s[0]      = In_valid;
  assign ctrl_s[0]       = In_ctrl;
  assign data_s[0]       = In_data;
  assign In_ready        = ready_s[0];
  assign ready_s[STAGES] = Out_ready;
  assign Out_valid       = valid_s[STAGES];
  assign Out_data        = data_s[STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    pipe_skid_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_slot (
      .clk       (Clk),
      .rst_n     (Rst),
      .flush     (Flush),
      .in_valid  (valid_s[i]),
      .in_ready  (ready_s[i]),
      .in_ctrl   (ctrl_s[i]),
      .in_data   (data_s[i]),
      .out_valid (valid_s[i+1]),
      .out_ready (ready_s[i+1]),
      .out_ctrl  (ctrl_s[i+1]),
      .out_data  (data_s[i+1])
    );
  end

  // A drained slot keeps its last ctrl, so bubbles are masked here.
  always_comb begin
    if (Out_valid) begin
      Out_ctrl = ctrl_s[STAGES];
    end else begin
      Out_ctrl = '0;
    end
  end

`ifdef PIPE_REG_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating stall/bubble event counters; Flush does not clear them.
  always_comb begin
    if (Out_valid && !Out_ready) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (!Out_valid && Out_ready) begin
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign Stall_cnt  = stall_cnt_q;
  assign Bubble_cnt = bubble_cnt_q;
`else
  assign Stall_cnt  = 32'd0;
  assign Bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of pipe_stage_reg with STAGES=2.
module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          Clk;
  logic          Rst;
  logic          In_valid;
  logic          In_ready;
  logic [CW-1:0] In_ctrl;
  logic [DW-1:0] In_data;
  logic          Out_valid;
  logic          Out_ready;
  logic [CW-1:0] Out_ctrl;
  logic [DW-1:0] Out_data;
  logic          Flush;
  logic [31:0]   Stall_cnt;
  logic [31:0]   Bubble_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STAGES(2)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .In_valid   (In_valid),
    .In_ready   (In_ready),
    .In_ctrl    (In_ctrl),
    .In_data    (In_data),
    .Out_valid  (Out_valid),
    .Out_ready  (Out_ready),
    .Out_ctrl   (Out_ctrl),
    .Out_data   (Out_data),
    .Flush      (Flush),
    .Stall_cnt  (Stall_cnt),
    .Bubble_cnt (Bubble_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    In_valid = 1'b0; In_ctrl = '0; In_data = '0; Out_ready = 1'b0; Flush = 1'b0;
    Rst = 1'b0;
    step(); step();
    Rst = 1'b1;
    step();
  endtask

  task automatic push_stalled(input int n, input logic [DW-1:0] base);
    Out_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      In_valid = 1'b1; In_data = base + DW'(k); In_ctrl = 4'hF;
      step();
    end
    In_valid = 1'b0;
  endtask

  task automatic test_reset();
    In_valid = 1'b0; In_ctrl = '0; In_data = '0; Out_ready = 1'b0; Flush = 1'b0;
    Rst = 1'b0;
    step();
    checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", Out_valid); end
    checks++; if (Out_ctrl !== 4'h0) begin errors++; $display("FAIL reset_out_ctrl got=%h exp=0", Out_ctrl); end
    checks++; if (Out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", Out_data); end
    checks++; if (In_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", In_ready); end
    checks++; if (Stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", Stall_cnt); end
    checks++; if (Bubble_cnt !== 32'd0) begin errors++; $display("FAIL reset_bubble_cnt got=%0d exp=0", Bubble_cnt); end
    Rst = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic exp_v;
    logic [DW-1:0] exp_d;
    do_reset();
    Out_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      if (j < 8) begin
        In_valid = 1'b1; In_data = DW'(j + 1); In_ctrl = CW'(j + 1);
      end else begin
        In_valid = 1'b0; In_data = '0; In_ctrl = '0;
      end
      step();
      // Sample follows edge j+1; item k is visible after edge k+2.
      exp_v = ((j + 1) >= 2) && ((j + 1) <= 9);
      exp_d = DW'(j);
      checks++; if (Out_valid !== exp_v) begin errors++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", j + 1, Out_valid, exp_v); end
      checks++; if (In_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", j + 1, In_ready); end
      if (exp_v) begin
        checks++; if (Out_data !== exp_d) begin errors++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", j + 1, Out_data, exp_d); end
        checks++; if (Out_ctrl !== exp_d[CW-1:0]) begin errors++; $display("FAIL stream_ctrl cyc=%0d got=%h exp=%h", j + 1, Out_ctrl, exp_d[CW-1:0]); end
      end else begin
        checks++; if (Out_ctrl !== 4'h0) begin errors++; $display("FAIL stream_bubble_ctrl cyc=%0d got=%h exp=0", j + 1, Out_ctrl); end
      end
    end
  endtask

  task automatic test_backpressure();
    int accepts;
    int exp;
    logic rdy;
    do_reset();
    Out_ready = 1'b0;
    accepts = 0;
    for (int k = 0; k < 8; k++) begin
      In_valid = 1'b1; In_data = 64'h11 + DW'(accepts); In_ctrl = 4'h3;
      rdy = In_ready;
      step();
      if (rdy) accepts++;
    end
    In_valid = 1'b0;
    checks++; if (accepts !== 4) begin errors++; $display("FAIL bp_accepts got=%0d exp=4", accepts); end
    checks++; if (In_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", In_ready); end
    checks++; if (Out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%b exp=1", Out_valid); end
    checks++; if (Out_data !== 64'h11) begin errors++; $display("FAIL bp_head_data got=%h exp=11", Out_data); end
    Out_ready = 1'b1;
    exp = 0;
    for (int k = 0; k < 12; k++) begin
      if (Out_valid) begin
        checks++; if (Out_data !== 64'h11 + DW'(exp)) begin errors++; $display("FAIL bp_drain_data got=%h exp=%h", Out_data, 64'h11 + DW'(exp)); end
        exp++;
      end
      step();
    end
    checks++; if (exp !== 4) begin errors++; $display("FAIL bp_drain_count got=%0d exp=4", exp); end
    checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", Out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    push_stalled(3, 64'h21);
    checks++; if (In_ready !== 1'b1) begin errors++; $display("FAIL flush_pre_ready got=%b exp=1", In_ready); end
    Flush = 1'b1; In_valid = 1'b1; In_data = 64'hAA; In_ctrl = 4'hA;
    step();
    Flush = 1'b0; In_valid = 1'b0;
    checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", Out_valid); end
    checks++; if (Out_ctrl !== 4'h0) begin errors++; $display("FAIL flush_out_ctrl got=%h exp=0", Out_ctrl); end
    checks++; if (In_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", In_ready); end
    Out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak got=%b data=%h exp=0", Out_valid, Out_data); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    push_stalled(3, 64'h31);
    checks++; if (Out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got=%b exp=1", Out_valid); end
    #2;
    Rst = 1'b0;
    #1;
    checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got=%b exp=0", Out_valid); end
    checks++; if (Out_ctrl !== 4'h0) begin errors++; $display("FAIL areset_out_ctrl got=%h exp=0", Out_ctrl); end
    #1;
    Rst = 1'b1;
    step();
    checks++; if (In_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%b exp=1", In_ready); end
    checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL areset_post_valid got=%b exp=0", Out_valid); end
  endtask

  task automatic test_random();
    logic [CW+DW-1:0] sb [$];
    logic [CW+DW-1:0] head;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    logic in_fire, out_fire;
    do_reset();
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 10000; c++) begin
      if (prev_stall) begin
        checks++; if (Out_valid !== 1'b1 || Out_data !== prev_data) begin errors++; $display("FAIL rand_stable cyc=%0d got=%b/%h exp=1/%h", c, Out_valid, Out_data, prev_data); end
      end
      In_valid = 1'($urandom_range(0, 1));
      In_data = {$urandom, $urandom};
      In_ctrl = CW'($urandom_range(0, 15));
      Out_ready = 1'($urandom_range(0, 1));
      in_fire = In_valid & In_ready;
      out_fire = Out_valid & Out_ready;
      if (out_fire) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL rand_spurious cyc=%0d got=%h exp=none", c, Out_data);
        end else begin
          head = sb.pop_front();
          checks++; if ({Out_ctrl, Out_data} !== head) begin errors++; $display("FAIL rand_order cyc=%0d got=%h exp=%h", c, {Out_ctrl, Out_data}, head); end
        end
      end
      if (in_fire) sb.push_back({In_ctrl, In_data});
      prev_stall = Out_valid & ~Out_ready;
      prev_data = Out_data;
      step();
    end
    In_valid = 1'b0;
    Out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (Out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL rand_drain_spurious got=%h exp=none", Out_data);
        end else begin
          head = sb.pop_front();
          checks++; if ({Out_ctrl, Out_data} !== head) begin errors++; $display("FAIL rand_drain got=%h exp=%h", {Out_ctrl, Out_data}, head); end
        end
      end
      step();
    end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL rand_lost got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_perf();
    do_reset();
    Out_ready = 1'b0;
    In_valid = 1'b1; In_data = 64'h5; In_ctrl = 4'h1;
    step();
    In_valid = 1'b0;
    step();
    checks++; if (Out_valid !== 1'b1) begin errors++; $display("FAIL perf_valid got=%b exp=1", Out_valid); end
    for (int k = 0; k < 5; k++) step();
`ifdef PIPE_REG_PERF_EN
    checks++; if (Stall_cnt !== 32'd5) begin errors++; $display("FAIL perf_stall got=%0d exp=5", Stall_cnt); end
    checks++; if (Bubble_cnt !== 32'd0) begin errors++; $display("FAIL perf_bubble0 got=%0d exp=0", Bubble_cnt); end
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) step();
    checks++; if (Stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_saturate got=%h exp=ffffffff", Stall_cnt); end
    Out_ready = 1'b1;
    step();
    step();
    checks++; if (Bubble_cnt !== 32'd1) begin errors++; $display("FAIL perf_bubble got=%0d exp=1", Bubble_cnt); end
`else
    checks++; if (Stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_off_stall got=%0d exp=0", Stall_cnt); end
    Out_ready = 1'b1;
    step();
    step();
    checks++; if (Bubble_cnt !== 32'd0) begin errors++; $display("FAIL perf_off_bubble got=%0d exp=0", Bubble_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

- Parametrised, elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing the fixed-field per-stage registers.
- Carries a control bundle and a data bundle through `STAGES` chained skid slots with a valid/ready handshake, synchronous flush and bubble-safe control clearing.
- Upstream stall is honoured without a combinational ready path, so the memory and writeback stages can back-pressure the pipe cleanly.

## Interface
Parameters:
- `DATA_W`, 64, width of data bundle (ALU result, memory data, etc.)
- `CTRL_W`, 4, width of control bundle (RegWrite, MemToReg, dest reg, ...); forced to zero in bubbles
- `STAGES`, 1, number of chained slots; must be ≥1, and 0 is an elaboration error

Ports:
- `Clk`  in  1  the block's single clock; all state updates on its rising edge
- `Rst`  in  1  reset; asynchronous and active-low
- `In_valid`  in  1  upstream holds a valid item
- `In_ready`  out  1  block can accept; driven directly from a register
- `In_ctrl`  in  CTRL_W  upstream control bundle
- `In_data`  in  DATA_W  upstream data bundle
- `Out_valid`  out  1  item available downstream
- `Out_ready`  in  1  downstream accepts
- `Out_ctrl`  out  CTRL_W  control bundle; all-zero whenever `Out_valid`=0
- `Out_data`  out  DATA_W  data bundle
- `Flush`  in  1  synchronous kill of all in-flight items
- `Stall_cnt`  out  32  cycles with `Out_valid`=1, `Out_ready`=0 (see Configuration)
- `Bubble_cnt`  out  32  cycles with `Out_valid`=0, `Out_ready`=1 (see Configuration)

## Operation
- Fire events: in_fire = `In_valid` & `In_ready`; out_fire = `Out_valid` & `Out_ready`.
- Each slot has a main register, a skid register and a 2-bit state, chained slot to slot with the same handshake.
- Slot states and transitions:
  - EMPTY: input fire → ONE (main loads the input).
  - ONE: input fire only → TWO (skid loads the input); output fire only → EMPTY; both → ONE (main reloads from the input).
  - TWO: output fire → ONE (main loads from skid); upstream ready is 0, so no input is accepted.
- Slot upstream ready is a register equal to (next state ≠ TWO).
- `Out_valid` and `Out_data` stay stable while `Out_valid`=1 and `Out_ready`=0; a valid is never withdrawn except by `Flush` or reset.
- `Flush`: every slot goes to EMPTY on the next edge and all ctrl registers clear. Data registers are not cleared.
  - `Flush` overrides in_fire in the same cycle; that input is dropped.
  - `In_ready` is 1 on the cycle after `Flush`.
- Capacity is 2×`STAGES` items. With `Out_ready` held at 0, `In_ready` falls after exactly 2×`STAGES` accepts.
- Ordering is strict FIFO; no item is duplicated or lost except by `Flush`.

## Timing
- Reset (async assert, sync release) values: all slots EMPTY, `Out_valid`=0, `Out_ctrl`=0, `Out_data`=0, `In_ready`=1, `Stall_cnt`=0, `Bubble_cnt`=0.
- Latency: `STAGES` cycles from in_fire to `Out_valid`, when there is no back-pressure.
- Throughput: 1 item/cycle sustained.
- `In_ready` responds to `Out_ready` with a delay of 1 cycle per slot; the skid register absorbs the in-flight item.
- Reset asserted mid-transfer discards all items immediately, with no completion.

## Configuration
- Macro: `PIPE_REG_PERF_EN`.
- Defined:
  - `Stall_cnt` and `Bubble_cnt` are 32-bit counters that saturate at 0xFFFFFFFF.
  - Cleared by reset only, not by `Flush`.
  - Each increments on the edge after a cycle in which its condition holds.
- Undefined: both ports are tied to 0 and no counter logic is synthesised. The port list is identical in both builds.

## Structure
- Shared package `pipe_pkg`:
  - slot-state typedef (EMPTY/ONE/TWO)
  - `PERF_CNT_W`=32
  - default `DATA_W`/`CTRL_W` constants for each pipeline boundary
- Sub-module `pipe_skid_slot`: one slot (main register, skid register, state, registered ready), instantiated `STAGES` times in a generate loop. The top level adds the ctrl gating and the counters.

## Test plan
- Reset and stream: `STAGES`=2; after reset, drive 8 items with data 0x1..0x8 and `Out_ready`=1 → `Out_valid` rises 2 cycles after the first accept; 0x1..0x8 appear on consecutive cycles.
- Back-pressure: `STAGES`=2, `Out_ready`=0 → `In_ready` falls after exactly 4 accepts. Release → 4 items drain in order with no loss or duplication.
- Flush with simultaneous input: 3 items in flight, `Flush`=1 together with in_fire of 0xAA → next cycle `Out_valid`=0, `Out_ctrl`=0, `In_ready`=1; 0xAA never appears at the output.
- Async reset mid-burst: assert `Rst`=0 between clock edges → `Out_valid` and `Out_ctrl` go to 0 before the next edge; after release, `In_ready`=1.
- Random handshake: 10k cycles of random `In_valid`/`Out_ready` against a scoreboard → output is an exact FIFO of the input, and `Out_data` is stable under stall.
- Perf (macro defined): hold `Out_ready`=0 for 5 cycles with `Out_valid`=1 → `Stall_cnt`=5. Preload a counter at 0xFFFFFFFE and run 3 more stall cycles → it holds at 0xFFFFFFFF.
